// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider: FSM state encoding,
// default operand width and the start-to-done latency that follows from it.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_e;

    localparam int DIV_W   = 32;
    localparam int DIV_LAT = DIV_W + 2;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference on no borrow and shift the outcome into quo.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;

    // rem < dvs on entry, so a successful difference always fits in WIDTH bits
    always_comb begin
        shifted   = {rem_i, quo_i[WIDTH-1]};
        no_borrow = (shifted >= {1'b0, dvs_i});
        diff      = shifted[WIDTH-1:0] - dvs_i;
        rem_o     = no_borrow ? diff : shifted[WIDTH-1:0];
        quo_o     = {quo_i[WIDTH-2:0], no_borrow};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (WIDTH RUN steps + FIX + DONE).
// Define SEQ_DIVIDER_SIGNED_EN to honour signed_op; otherwise all operands are unsigned.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] step_rem, step_quo;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic dvd_neg, dvs_neg;

    always_comb begin
        dvd_neg = signed_op & dividend[WIDTH-1];
        dvs_neg = signed_op & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
    assign dvd_mag          = dividend;
    assign dvs_mag          = divisor;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d = '0;
                    if (divisor == '0) begin
                        // zero divisor resolves immediately with the raw dividend
                        state_d     = DONE;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        rem_d   = '0;
                        quo_d   = dvd_mag;
                        dvs_d   = dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
`endif
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
`else
                quotient_d  = quo_q;
                remainder_d = rem_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // working datapath needs no reset: it is always loaded on an accepted start
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
`endif
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, unsigned/signed results, zero divisor,
// ignored start while running, reset abort and back-to-back operation.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // n = number of edges from the start-sampling edge until done is seen high
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic seen;

        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        check("rst_quo", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        rst = 1'b0;
        tick();

        launch(1'b0, 32'd100, 32'd7);
        check("u100_7_busy", {31'b0, busy}, 32'd1);
        wait_done(n);
        check("u100_7_lat", 32'(n), 32'd34);
        check("u100_7_quo", quotient, 32'd14);
        check("u100_7_rem", remainder, 32'd2);
        check("u100_7_dbz", {31'b0, div_by_zero}, 32'd0);
        check("u100_7_busy_done", {31'b0, busy}, 32'd0);
        tick();
        check("u100_7_done_pulse", {31'b0, done}, 32'd0);
        check("u100_7_hold", quotient, 32'd14);

        launch(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done(n);
`ifdef SEQ_DIVIDER_SIGNED_EN
        check("s_n100_7_quo", quotient, 32'hFFFF_FFF2);
        check("s_n100_7_rem", remainder, 32'hFFFF_FFFE);
`else
        check("s_n100_7_quo", quotient, 32'h2492_4916);
        check("s_n100_7_rem", remainder, 32'd2);
`endif

        launch(1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_done(n);
`ifdef SEQ_DIVIDER_SIGNED_EN
        check("s_100_n7_quo", quotient, 32'hFFFF_FFF2);
        check("s_100_n7_rem", remainder, 32'd2);
`else
        check("s_100_n7_quo", quotient, 32'd0);
        check("s_100_n7_rem", remainder, 32'd100);
`endif

        tick();
        launch(1'b0, 32'h1234_5678, 32'd0);
        check("dz_busy", {31'b0, busy}, 32'd0);
        wait_done(n);
        check("dz_lat", 32'(n), 32'd1);
        check("dz_quo", quotient, 32'hFFFF_FFFF);
        check("dz_rem", remainder, 32'h1234_5678);
        check("dz_flag", {31'b0, div_by_zero}, 32'd1);

        tick();
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
`ifdef SEQ_DIVIDER_SIGNED_EN
        check("s_min_n1_quo", quotient, 32'h8000_0000);
        check("s_min_n1_rem", remainder, 32'd0);
`else
        check("s_min_n1_quo", quotient, 32'd0);
        check("s_min_n1_rem", remainder, 32'h8000_0000);
`endif
        check("s_min_n1_dbz", {31'b0, div_by_zero}, 32'd0);

        tick();
        launch(1'b0, 32'd1000, 32'd10);
        repeat (9) tick();
        launch(1'b0, 32'd5, 32'd1);
        wait_done(n);
        check("ign_lat", 32'(n + 10), 32'd34);
        check("ign_quo", quotient, 32'd100);
        check("ign_rem", remainder, 32'd0);

        tick();
        launch(1'b0, 32'd100, 32'd7);
        repeat (4) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_quo", quotient, 32'd0);
        check("abort_rem", remainder, 32'd0);
        check("abort_dbz", {31'b0, div_by_zero}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", {31'b0, seen}, 32'd0);

        launch(1'b0, 32'd200, 32'd9);
        wait_done(n);
        check("b2b_first_quo", quotient, 32'd22);
        check("b2b_first_rem", remainder, 32'd2);
        launch(1'b0, 32'd50, 32'd5);
        check("b2b_accept_busy", {31'b0, busy}, 32'd1);
        wait_done(n);
        check("b2b_lat", 32'(n), 32'd34);
        check("b2b_quo", quotient, 32'd10);
        check("b2b_rem", remainder, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
